// File: rtl/srl16_fifo.sv
// ---------------------------------------------------------------------------------------------
// srl16_fifo
//
// Shallow synchronous FIFO built on a WIDTH-wide bank of 16-entry shift registers, the same
// write-shifts-in / address-selects-out structure as an SRL16 LUT primitive. A write shifts the
// whole bank by one (sr[0] is always the newest entry). The read address is derived from the
// occupancy counter (addr = count-1), so the oldest entry is always the one selected. Storage
// never moves on a read; only the counter changes.
//
// Output mode is selected by the SRL16_FIFO_OREG_EN macro:
//   undefined : first-word-fall-through, DOUT = head combinationally, 0 while empty
//   defined   : registered standard-read, DOUT loads the head on an accepted read and holds
//
// Parameters:
//   WIDTH     data width in bits (1..64)
//   AF_LEVEL  ALMOST_FULL asserts when occupancy >= AF_LEVEL (1..15)
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset, dominates WR_EN/RD_EN
//   DIN          write data
//   WR_EN        write request, accepted when not FULL
//   RD_EN        read request, accepted when not EMPTY
//   DOUT         read data (see output modes above)
//   EMPTY        occupancy == 0
//   FULL         occupancy == 16
//   ALMOST_FULL  occupancy >= AF_LEVEL
//   COUNT        occupancy, 0..16
//   OVERFLOW     one-cycle pulse after a write was rejected (WR_EN while FULL)
//   UNDERFLOW    one-cycle pulse after a read was rejected (RD_EN while EMPTY)
// ---------------------------------------------------------------------------------------------
module srl16_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             WR_EN,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic [4:0]       COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int unsigned Depth    = 16;
    localparam logic [4:0]  DepthCnt = 5'd16;
    localparam logic [4:0]  AfLevel  = 5'(AF_LEVEL);

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [4:0]       count_q;
    logic [4:0]       count_d;
    logic             empty_q;
    logic             full_q;
    logic             almost_full_q;
    logic             overflow_q;
    logic             underflow_q;

    // Shift-register bank, one 16-deep column per data bit; sr[0] is the newest entry.
    logic [WIDTH-1:0] sr [Depth];

    logic             wr;
    logic             rd;
    logic [3:0]       addr;
    logic [WIDTH-1:0] head;

    // -----------------------------------------------------------------------------------------
    // Handshake gating
    // -----------------------------------------------------------------------------------------
    // Flags are registered, so gating only sees count state: no combinational path from the
    // request inputs to any status output. Reset also blocks the storage shift, since the
    // storage itself has no reset.
    assign wr = WR_EN & ~full_q  & ~RST;
    assign rd = RD_EN & ~empty_q & ~RST;

    // -----------------------------------------------------------------------------------------
    // Occupancy counter
    // -----------------------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        unique case ({wr, rd})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;   // both or neither: occupancy holds
        endcase
    end

    // Flags are decoded from the next count so they line up with COUNT after each edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q       <= 5'd0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            count_q       <= count_d;
            empty_q       <= (count_d == 5'd0);
            full_q        <= (count_d == DepthCnt);
            almost_full_q <= (count_d >= AfLevel);
            overflow_q    <= WR_EN & full_q;
            underflow_q   <= RD_EN & empty_q;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Storage: pure shift on accepted write, never cleared (matches SRL primitives)
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (wr) begin
            sr[0] <= DIN;
            for (int i = 1; i < Depth; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Oldest entry sits at count-1. With count == 16 the low nibble is 0 and the subtraction
    // wraps to 15, which is exactly the oldest slot. With count == 0 the address is 15 but the
    // selected (possibly stale) word is masked by EMPTY.
    assign addr = count_q[3:0] - 4'd1;
    assign head = sr[addr];

    // -----------------------------------------------------------------------------------------
    // Read data path
    // -----------------------------------------------------------------------------------------
`ifdef SRL16_FIFO_OREG_EN
    logic [WIDTH-1:0] dout_q;

    // Sampled before the shift of a simultaneous write lands, so it is still the oldest entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q <= '0;
        end else if (rd) begin
            dout_q <= head;
        end
    end

    assign DOUT = dout_q;
`else
    assign DOUT = empty_q ? '0 : head;
`endif

    // -----------------------------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------------------------
    assign EMPTY       = empty_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = almost_full_q;
    assign COUNT       = count_q;
    assign OVERFLOW    = overflow_q;
    assign UNDERFLOW   = underflow_q;

endmodule
